// File: rtl/recv_fifo.sv
// Serial frame receiver feeding a first-word-fall-through output FIFO.
// Ports: clk, i_rst_n (async), i_sclr, i_en/i_dat (serial in), i_rd,
//        o_valid/o_byte/o_full (FIFO), o_perr/o_ferr/o_ovf pulses, o_err_cnt.
// Optional: define RECV_ERRCNT_EN to build the saturating bad-frame counter.
module recv_fifo #(
  parameter int DATA_W = 8,
  parameter int PARITY = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_sclr,
  input  logic              i_en,
  input  logic              i_dat,
  input  logic              i_rd,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_byte,
  output logic              o_full,
  output logic              o_perr,
  output logic              o_ferr,
  output logic              o_ovf,
  output logic [7:0]        o_err_cnt
);

  localparam int CW = $clog2(DATA_W);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic [AW:0] FULL_N = (AW + 1)'(DEPTH);
  localparam logic PAR_ODD = (PARITY == 1);
  localparam logic HAS_PAR = (PARITY != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   sh_d;
  logic                pm_q;
  logic                pm_d;
  logic                stop_ev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pm_d    = pm_q;
    stop_ev = 1'b0;
    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          if (!i_dat) begin
            state_d = DATA;
            cnt_d   = '0;
            pm_d    = 1'b0;
          end
        end
        DATA: begin
          sh_d = {i_dat, sh_q[DATA_W-1:1]};
          if (cnt_q == LAST) begin
            state_d = HAS_PAR ? PAR : STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAR: begin
          pm_d    = i_dat != ((^sh_q) ^ PAR_ODD);
          state_d = STOP;
        end
        STOP: begin
          stop_ev = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pm_q    <= 1'b0;
    end else if (i_sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pm_q    <= pm_d;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic              good;
  logic              pop;
  logic              push;
  logic              ferr_ev;
  logic              perr_ev;
  logic              ovf_ev;

  assign o_valid = occ != '0;
  assign o_full  = occ == FULL_N;
  assign o_byte  = o_valid ? mem[rd_ptr] : '0;

  // A pop in the same cycle frees the slot, so full+pop still accepts.
  assign pop     = i_rd & o_valid;
  assign good    = stop_ev & i_dat & ~pm_q;
  assign push    = good & (~o_full | pop);
  assign ovf_ev  = good & o_full & ~pop;
  assign ferr_ev = stop_ev & ~i_dat;
  assign perr_ev = stop_ev & pm_q;

  always_ff @(posedge clk) begin
    if (push && !i_sclr) begin
      mem[wr_ptr] <= sh_q;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      o_perr <= 1'b0;
      o_ferr <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (i_sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      o_perr <= 1'b0;
      o_ferr <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      o_perr <= perr_ev;
      o_ferr <= ferr_ev;
      o_ovf  <= ovf_ev;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef RECV_ERRCNT_EN
  logic [7:0] err_q;
  logic       bad;

  // ovf only fires on otherwise-good frames, so one frame bumps at most once.
  assign bad = ferr_ev | perr_ev | ovf_ev;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else if (i_sclr) begin
      err_q <= '0;
    end else if (bad && err_q != 8'hFF) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign o_err_cnt = err_q;
`else
  assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_recv_fifo.sv
// Scoreboard bench for recv_fifo: queue model of the FIFO,
// tagged expectations checked by a negedge monitor.
module tb_recv_fifo;

  localparam int DW    = 8;
  localparam int PAR   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_sclr;
  logic          i_en;
  logic          i_dat;
  logic          i_rd;
  logic          o_valid;
  logic [DW-1:0] o_byte;
  logic          o_full;
  logic          o_perr;
  logic          o_ferr;
  logic          o_ovf;
  logic [7:0]    o_err_cnt;

  always #5 clk = ~clk;

  recv_fifo #(
    .DATA_W(DW),
    .PARITY(PAR),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .i_rst_n  (rst_n),
    .i_sclr   (i_sclr),
    .i_en     (i_en),
    .i_dat    (i_dat),
    .i_rd     (i_rd),
    .o_valid  (o_valid),
    .o_byte   (o_byte),
    .o_full   (o_full),
    .o_perr   (o_perr),
    .o_ferr   (o_ferr),
    .o_ovf    (o_ovf),
    .o_err_cnt(o_err_cnt)
  );

  typedef struct {
    int         tag;
    int         n;
    logic [2:0] vec;
    logic [7:0] ec;
  } st_t;

  typedef struct {
    int         tag;
    logic [7:0] b;
  } pe_t;

  int         checks   = 0;
  int         failures = 0;
  int         edge_n   = 0;
  int         ecnt     = 0;
  bit         rd_mode  = 0;
  bit         gap      = 0;
  bit         force_rd = 0;
  st_t        cq[$];
  pe_t        pq[$];
  logic [7:0] mq[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (pq.size() > 0 && pq[0].tag == edge_n) begin
      checks++;
      if (!o_valid || o_byte !== pq[0].b) begin
        failures++;
        $display("FAIL pop_data edge=%0d valid=%b byte=%h expected %h",
                 edge_n, o_valid, o_byte, pq[0].b);
      end
      void'(pq.pop_front());
    end
    if (cq.size() > 0 && cq[0].tag == edge_n) begin
      checks++;
      if (o_valid !== (cq[0].n > 0) ||
          o_full !== (cq[0].n == DEPTH) ||
          {o_perr, o_ferr, o_ovf} !== cq[0].vec ||
          o_err_cnt !== cq[0].ec) begin
        failures++;
        $display("FAIL state edge=%0d v/f/pfo/ec=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                 edge_n, o_valid, o_full, {o_perr, o_ferr, o_ovf}, o_err_cnt,
                 cq[0].n > 0, cq[0].n == DEPTH, cq[0].vec, cq[0].ec);
      end
      void'(cq.pop_front());
    end else if ({o_perr, o_ferr, o_ovf} != 3'b000) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse edge=%0d pfo=%b expected 000",
               edge_n, {o_perr, o_ferr, o_ovf});
    end
  end

  function automatic logic rdbit();
    return rd_mode && ($urandom_range(0, 3) == 0);
  endfunction

  // One clock: drive inputs, advance the model for the coming edge.
  task automatic cyc(input logic en, input logic dat, input logic rd,
                     input logic sclr, input logic fin,
                     input logic [2:0] bad, input logic [7:0] d);
    logic [2:0] vec;
    vec    = 3'b000;
    i_en   = en;
    i_dat  = dat;
    i_rd   = rd;
    i_sclr = sclr;
    if (sclr) begin
      mq.delete();
      ecnt = 0;
    end else begin
      if (rd && mq.size() > 0) begin
        pq.push_back('{tag: edge_n, b: mq[0]});
        void'(mq.pop_front());
      end
      if (en && fin) begin
        if (bad != 3'b000) vec = bad;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else vec = 3'b001;
`ifdef RECV_ERRCNT_EN
        if (vec != 3'b000 && ecnt < 255) ecnt++;
`endif
      end
    end
    cq.push_back('{tag: edge_n + 1, n: mq.size(), vec: vec, ec: 8'(ecnt)});
    @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b, input logic fin,
                         input logic [2:0] bad, input logic [7:0] d);
    int g;
    g = gap ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < g; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), rdbit(), 1'b0, 1'b0, 3'b0, 8'h0);
    cyc(1'b1, b, rdbit() | (fin & force_rd), 1'b0, fin, bad, d);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok,
                            input logic stop);
    logic p;
    p = (PAR == 1) ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
    if (!par_ok) p = ~p;
    bit_out(1'b0, 1'b0, 3'b0, 8'h0);
    for (int i = 0; i < DW; i++) bit_out(d[i], 1'b0, 3'b0, 8'h0);
    bit_out(p, 1'b0, 3'b0, 8'h0);
    bit_out(stop, 1'b1, {~par_ok, ~stop, 1'b0}, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b1, rdbit(), 1'b0, 1'b0, 3'b0, 8'h0);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b0, 8'h0);
  endtask

  task automatic clear();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b0, 8'h0);
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({o_valid, o_full, o_perr, o_ferr, o_ovf} != 5'b0 ||
        o_byte != '0 || o_err_cnt != 8'd0) begin
      failures++;
      $display("FAIL %s v/f/pfo=%b/%b/%b byte=%h ec=%0d expected all zero",
               nm, o_valid, o_full, {o_perr, o_ferr, o_ovf}, o_byte, o_err_cnt);
    end
  endtask

  task automatic do_reset();
    cq.delete();
    pq.delete();
    mq.delete();
    ecnt  = 0;
    i_en  = 1'b0;
    i_rd  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_hold");
    rst_n = 1'b1;
  endtask

  logic [7:0] rd8;

  initial begin
    rst_n  = 1'b0;
    i_sclr = 1'b0;
    i_en   = 1'b0;
    i_dat  = 1'b1;
    i_rd   = 1'b0;
    #1;
    chk_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // good 0xA5 then pop
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(1);
    pop_n(1);
    idle(1);

    // parity error
    clear();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2);

    // framing error
    clear();
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2);

    // overflow on fifth, extra read on empty ignored
    clear();
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b1);
    idle(1);
    pop_n(5);

    // full with push and pop on the same edge
    clear();
    for (int k = 0; k < DEPTH; k++) send_frame(8'(8'h10 + k), 1'b1, 1'b1);
    force_rd = 1;
    send_frame(8'h77, 1'b1, 1'b1);
    force_rd = 0;
    pop_n(DEPTH + 1);

    // reset after four data bits
    clear();
    rd8 = 8'h3C;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 8'h0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, rd8[i], 1'b0, 1'b0, 1'b0, 3'b0, 8'h0);
    do_reset();
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(1);
    pop_n(1);

    // randomized traffic
    gap     = 1;
    rd_mode = 1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 40) == 0) clear();
      send_frame(8'($urandom), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) != 0);
      idle(int'($urandom_range(0, 2)));
    end

    gap     = 0;
    rd_mode = 0;
    pop_n(DEPTH + 2);
    @(negedge clk);
    #1;
    checks++;
    if (cq.size() != 0 || pq.size() != 0) begin
      failures++;
      $display("FAIL leftover state=%0d pops=%0d expected 0/0",
               cq.size(), pq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recv_fifo.md
RECV_FIFO -- requirements
Module: recv_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data bits per frame (5..9 legal).
REQ-002 SHALL provide parameter PARITY, default 1, parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL provide parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-004 SHALL have clk input 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have i_rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have i_sclr input 1, synchronous active-high clear.
REQ-007 SHALL have i_en input 1, bit-sample strobe; i_dat is sampled only when high.
REQ-008 SHALL have i_dat input 1, serial line level.
REQ-009 SHALL have i_rd input 1, pop request for the FIFO head.
REQ-010 SHALL have o_valid output 1, FIFO not empty.
REQ-011 SHALL have o_byte output DATA_W, FIFO head (first-word-fall-through).
REQ-012 SHALL have o_full output 1, FIFO holds DEPTH words.
REQ-013 SHALL have o_perr, o_ferr, o_ovf outputs 1 each, one-cycle error pulses.
REQ-014 SHALL have o_err_cnt output 8, bad-frame count.

Function
REQ-015 FSM states IDLE, DATA, PAR, STOP; state advances only in cycles with i_en=1.
REQ-016 IDLE: i_dat=0 -> DATA with bit count 0; i_dat=1 -> stay IDLE.
REQ-017 DATA: shift LSB-first (new bit enters MSB, register shifts right); after DATA_W bits -> PAR if PARITY!=0, else STOP.
REQ-018 PAR: record mismatch when parity bit != XOR of data bits XOR (PARITY==1); always -> STOP.
REQ-019 STOP: always -> IDLE; frame good when i_dat=1 and no parity mismatch.
REQ-020 Good frame SHALL be written to FIFO on the STOP-sample edge; o_valid high from the next cycle (latency 1 clk after stop strobe).
REQ-021 o_ferr SHALL pulse the cycle after a STOP sample with i_dat=0; o_perr SHALL pulse the same cycle on parity mismatch; both may pulse together; frame discarded.
REQ-022 Good frame arriving with FIFO full and no pop in that cycle SHALL be dropped, FIFO unchanged, o_ovf pulses the following cycle.
REQ-023 Push and pop in the same cycle when full SHALL both be accepted, no overflow.
REQ-024 i_rd with o_valid=1 SHALL pop head; i_rd with o_valid=0 SHALL be ignored.
REQ-025 i_rd SHALL operate regardless of i_en.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 i_sclr=1 SHALL behave as reset at the next edge, overriding all other inputs.

Reset
REQ-028 On i_rst_n=0 immediately: FSM IDLE, bit count 0, shift register 0, FIFO empty, o_valid=0, o_full=0, o_byte=0, all error pulses 0, o_err_cnt=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; no push or error pulse results.

Configuration
REQ-030 Macro RECV_ERRCNT_EN defined: o_err_cnt increments by 1 per discarded frame (ferr, perr or ovf; at most 1 per frame), saturating at 255.
REQ-031 Macro RECV_ERRCNT_EN undefined: no counter logic; o_err_cnt tied to 0.

Verification (DATA_W=8, PARITY=1, DEPTH=4, RECV_ERRCNT_EN defined unless noted)
REQ-032 Frame 0,1,0,1,0,0,1,0,1,par 1,stop 1 -> o_valid next cycle, o_byte=0xA5, no error pulses; i_rd pops -> o_valid=0.
REQ-033 Same frame with parity 0 -> o_perr one pulse, o_valid stays 0, o_err_cnt=1.
REQ-034 Frame 0x3C, correct parity, stop 0 -> o_ferr one pulse, nothing pushed, o_err_cnt=1.
REQ-035 Five good frames 0x01..0x05, no reads -> o_full after fourth, o_ovf on fifth, reads return 0x01..0x04, o_err_cnt=1.
REQ-036 i_rst_n low after 4 data bits -> all outputs 0; following frame 0x3C received intact, no errors.
REQ-037 Build without RECV_ERRCNT_EN, rerun REQ-033..035 -> same pulses, o_err_cnt stays 0.
